// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, reads Instruction_Memory and loads the IF/ID register.
// Define IFETCH_PERF_CNT_EN to implement the fetch/stall performance counters.
module if_fetch_ctrl #(
  parameter int              AddrBits  = 16,
  parameter int              DataWidth = 16,
  parameter logic [AddrBits-1:0] ResetPC = 16'h0000,
  parameter int              PCStep    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [AddrBits-1:0]  branch_target,
  input  logic                 halt,
  output logic [AddrBits-1:0]  ReadAddr,
  input  logic [DataWidth-1:0] ReadData,
  output logic [DataWidth-1:0] instr,
  output logic [AddrBits-1:0]  instr_pc,
  output logic                 instr_valid,
  output logic                 halted,
  output logic [15:0]          fetch_count,
  output logic [15:0]          stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [AddrBits-1:0]  pc_q, pc_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [AddrBits-1:0]  instr_pc_q, instr_pc_d;
  logic                 valid_q, valid_d;

  // REDIRECT differs from RUN only in where it returns; a stall there keeps the bubble.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    unique case (state_q)
      RUN, REDIRECT: begin
        if (halt) begin
          valid_d = 1'b0;
          state_d = HALT;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = '0;
          valid_d = 1'b0;
          state_d = REDIRECT;
        end else if (!stall) begin
          instr_d    = ReadData;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + AddrBits'(PCStep);
          state_d    = RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= ResetPC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign ReadAddr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALT);

`ifdef IFETCH_PERF_CNT_EN
  logic        active;
  logic        fetch_inc;
  logic        stall_inc;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  assign active    = (state_q != HALT) && !halt && !branch_taken;
  assign fetch_inc = active && !stall;
  assign stall_inc = active && stall;

  // Both counters saturate rather than wrap.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetch_inc && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
    if (stall_inc && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: stimulus pushes hand-computed IF/ID expectations,
// a negedge monitor pops and compares them. Memory model: mem[i] = 16'hA000 + i.
module tb_if_fetch_ctrl;

`ifdef IFETCH_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic [15:0] ReadAddr;
  logic [15:0] ReadData;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic [15:0] stall_count;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic [15:0] ra;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .ReadAddr      (ReadAddr),
    .ReadData      (ReadData),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  assign ReadData = 16'hA000 + ReadAddr;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; after the edge, record what IF/ID must hold.
  task automatic applyStimulus(input logic s, input logic b, input logic [15:0] t, input logic h,
                               input logic [15:0] e_instr, input logic [15:0] e_pc,
                               input logic e_valid, input logic [15:0] e_ra, input logic e_halted);
    exp_t e;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    halt          = h;
    @(posedge clk);
    e.instr  = e_instr;
    e.pc     = e_pc;
    e.valid  = e_valid;
    e.ra     = e_ra;
    e.halted = e_halted;
    exp_q.push_back(e);
    #1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
  endtask

  // Monitor: compares the registered outputs half a cycle after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("instr",       instr,              e.instr);
        checkOutput("instr_pc",    instr_pc,           e.pc);
        checkOutput("instr_valid", 16'(instr_valid),   16'(e.valid));
        checkOutput("ReadAddr",    ReadAddr,           e.ra);
        checkOutput("halted",      16'(halted),        16'(e.halted));
      end
    end
  end

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    halt          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid",  16'(instr_valid), 16'h0000);
    checkOutput("reset_ra",     ReadAddr,         16'h0000);
    checkOutput("reset_instr",  instr,            16'h0000);
    checkOutput("reset_halted", 16'(halted),      16'h0000);
    rst = 1'b0;

    // Run up to PC=5, then reset mid-run.
    applyStimulus(0, 0, 16'h0, 0, 16'hA000, 16'h0000, 1, 16'h0001, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA001, 16'h0001, 1, 16'h0002, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA002, 16'h0002, 1, 16'h0003, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA003, 16'h0003, 1, 16'h0004, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA004, 16'h0004, 1, 16'h0005, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid",  16'(instr_valid), 16'h0000);
    checkOutput("midrst_ra",     ReadAddr,         16'h0000);
    checkOutput("midrst_halted", 16'(halted),      16'h0000);
    checkOutput("midrst_fetch",  fetch_count,      16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Restart, then stall three cycles while A003 is in IF/ID.
    applyStimulus(0, 0, 16'h0, 0, 16'hA000, 16'h0000, 1, 16'h0001, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA001, 16'h0001, 1, 16'h0002, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA002, 16'h0002, 1, 16'h0003, 0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA003, 16'h0003, 1, 16'h0004, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 16'h0, 0, 16'hA003, 16'h0003, 1, 16'h0004, 0);
    checkOutput("stall_count_3", stall_count, PerfOn ? 16'd3 : 16'd0);
    applyStimulus(0, 0, 16'h0, 0, 16'hA004, 16'h0004, 1, 16'h0005, 0);
    checkOutput("fetch_count_5", fetch_count, PerfOn ? 16'd5 : 16'd0);

    // Branch wins over a same-edge stall.
    applyStimulus(1, 1, 16'h0040, 0, 16'h0000, 16'h0004, 0, 16'h0040, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'hA040, 16'h0040, 1, 16'h0041, 0);

    // Stall inside REDIRECT keeps the bubble and the PC.
    applyStimulus(0, 1, 16'h0050, 0, 16'h0000, 16'h0040, 0, 16'h0050, 0);
    applyStimulus(1, 0, 16'h0,    0, 16'h0000, 16'h0040, 0, 16'h0050, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'hA050, 16'h0050, 1, 16'h0051, 0);

    // Re-redirect while already in REDIRECT.
    applyStimulus(0, 1, 16'h0060, 0, 16'h0000, 16'h0050, 0, 16'h0060, 0);
    applyStimulus(0, 1, 16'h0070, 0, 16'h0000, 16'h0050, 0, 16'h0070, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'hA070, 16'h0070, 1, 16'h0071, 0);

    // PC wrap: mem[FFFF] = A000+FFFF truncated = 9FFF.
    applyStimulus(0, 1, 16'hFFFF, 0, 16'h0000, 16'h0070, 0, 16'hFFFF, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'h9FFF, 16'hFFFF, 1, 16'h0000, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'hA000, 16'h0000, 1, 16'h0001, 0);

    // Reach PC=7, then halt together with a branch.
    applyStimulus(0, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0005, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'hA005, 16'h0005, 1, 16'h0006, 0);
    applyStimulus(0, 0, 16'h0,    0, 16'hA006, 16'h0006, 1, 16'h0007, 0);
    applyStimulus(0, 1, 16'h0030, 1, 16'hA006, 16'h0006, 0, 16'h0007, 1);
    applyStimulus(0, 1, 16'h0099, 0, 16'hA006, 16'h0006, 0, 16'h0007, 1);
    applyStimulus(1, 0, 16'h0,    0, 16'hA006, 16'h0006, 0, 16'h0007, 1);
    applyStimulus(0, 0, 16'h0,    0, 16'hA006, 16'h0006, 0, 16'h0007, 1);
    applyStimulus(1, 1, 16'h0022, 1, 16'hA006, 16'h0006, 0, 16'h0007, 1);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("final_fetch_count", fetch_count, PerfOn ? 16'd12 : 16'd0);
    checkOutput("final_stall_count", stall_count, PerfOn ? 16'd4  : 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
